// File: rtl/dma_bus_arbiter_pkg.sv
// Shared state encodings and constants for the CPU-side DMA bus arbiter.
package dma_bus_arbiter_pkg;

   // Bytes moved by one OAM DMA and the PPU register that receives them.
   localparam int unsigned OAM_LEN      = 256;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

   // OAM sequencer. PEND waits for a CPU read cycle before halting.
   typedef enum logic [2:0] {
      OAM_IDLE  = 3'd0,
      OAM_PEND  = 3'd1,
      OAM_HALT  = 3'd2,
      OAM_ALIGN = 3'd3,
      OAM_READ  = 3'd4,
      OAM_WRITE = 3'd5
   } oam_dma_state_t;

   // DMC sample fetcher.
   typedef enum logic [2:0] {
      DMC_IDLE  = 3'd0,
      DMC_HALT  = 3'd1,
      DMC_DUMMY = 3'd2,
      DMC_ALIGN = 3'd3,
      DMC_READ  = 3'd4
   } dmc_dma_state_t;

   // True while the OAM sequencer actually holds the CPU suspended.
   function automatic logic oam_holds_cpu(input oam_dma_state_t s);
      return (s != OAM_IDLE) && (s != OAM_PEND);
   endfunction

endpackage

// File: rtl/dma_bus_arbiter_dmc_fetch_fsm.sv
// DMC sample fetch sequencer. Requests a get-cycle bus slot from the
// arbiter and returns the fetched byte with a one-cycle acknowledge.
module dma_bus_arbiter_dmc_fetch_fsm (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cpu_clk_en,
   input  logic       cpu_cyc_par,
   input  logic       cpu_re,
   input  logic       dmc_req,
   input  logic       oam_active,
   input  logic       slot_grant,
   input  logic [7:0] mem_rd_data,
   output logic       slot_req,
   output logic       busy,
   output logic       dmc_ack,
   output logic [7:0] dmc_data
);
   import dma_bus_arbiter_pkg::*;

   dmc_dma_state_t state_q, state_d;
   logic           ack_q, ack_d;
   logic [7:0]     data_q, data_d;

   // Next-state: everything moves only on the CPU-rate enable.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      data_d  = data_q;
      if (cpu_clk_en) begin
         ack_d = 1'b0;
         unique case (state_q)
            DMC_IDLE: begin
               // The ack cycle still sees the old request; do not refetch on it.
               if (dmc_req && !ack_q) begin
                  // With OAM already holding the CPU the halt/dummy cycles are
                  // absorbed, so go straight to waiting for a get slot.
                  if (oam_active)  state_d = DMC_READ;
                  else if (cpu_re) state_d = DMC_HALT;
               end
            end
            DMC_HALT:  state_d = DMC_DUMMY;
            DMC_DUMMY: state_d = cpu_cyc_par ? DMC_READ : DMC_ALIGN;
            DMC_ALIGN: state_d = DMC_READ;
            DMC_READ: begin
               if (slot_grant) begin
                  data_d  = mem_rd_data;
                  ack_d   = 1'b1;
                  state_d = DMC_IDLE;
               end
            end
            default: state_d = DMC_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= DMC_IDLE;
         ack_q   <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
      end
   end

   assign slot_req = (state_q == DMC_READ);
   assign busy     = (state_q != DMC_IDLE);
   assign dmc_ack  = ack_q;
   assign dmc_data = data_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU-side bus owner: sequences OAM DMA and DMC fetches, suspends the CPU
// while either holds the bus, and drives the single cpu_memory port.
module dma_bus_arbiter #(
   parameter int unsigned OAM_LEN      = dma_bus_arbiter_pkg::OAM_LEN,
   parameter logic [15:0] OAMDATA_ADDR = dma_bus_arbiter_pkg::OAMDATA_ADDR
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cpu_clk_en,
   input  logic        cpu_cyc_par,
   input  logic        oam_dma_start,
   input  logic [7:0]  oam_dma_page,
   input  logic        dmc_req,
   input  logic [15:0] dmc_addr,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_re,
   input  logic [7:0]  mem_rd_data,
   output logic [15:0] mem_addr,
   output logic        mem_re,
   output logic        cpu_sus,
   output logic        oam_wr_en,
   output logic [7:0]  oam_wr_data,
   output logic        dmc_ack,
   output logic [7:0]  dmc_data,
   output logic        dma_busy
);
   import dma_bus_arbiter_pkg::*;

   localparam logic [7:0] LAST_CNT = 8'(OAM_LEN - 1);

   oam_dma_state_t oam_state_q, oam_state_d;
   logic [7:0]     page_q, page_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [7:0]     oam_wr_data_q, oam_wr_data_d;

   logic           oam_active;
   logic           dmc_slot_req, dmc_slot_grant, dmc_busy;
   logic           oam_slot_grant;

   assign oam_active = oam_holds_cpu(oam_state_q);

   // Get (par=0) cycles are the only read slots; DMC wins any contested slot.
   assign dmc_slot_grant = dmc_slot_req && !cpu_cyc_par;
   assign oam_slot_grant = (oam_state_q == OAM_READ) && !cpu_cyc_par && !dmc_slot_req;

   dma_bus_arbiter_dmc_fetch_fsm u_dmc (
      .clock       (clock),
      .reset_n     (reset_n),
      .cpu_clk_en  (cpu_clk_en),
      .cpu_cyc_par (cpu_cyc_par),
      .cpu_re      (cpu_re),
      .dmc_req     (dmc_req),
      .oam_active  (oam_active),
      .slot_grant  (dmc_slot_grant),
      .mem_rd_data (mem_rd_data),
      .slot_req    (dmc_slot_req),
      .busy        (dmc_busy),
      .dmc_ack     (dmc_ack),
      .dmc_data    (dmc_data)
   );

   // OAM sequencer next-state: halt on a CPU read, align to a get cycle,
   // then alternate read/write until the last byte is written.
   always_comb begin
      oam_state_d   = oam_state_q;
      page_d        = page_q;
      cnt_d         = cnt_q;
      oam_wr_data_d = oam_wr_data_q;
      if (cpu_clk_en) begin
         unique case (oam_state_q)
            OAM_IDLE: begin
               if (oam_dma_start) begin
                  page_d      = oam_dma_page;
                  cnt_d       = 8'h00;
                  oam_state_d = cpu_re ? OAM_HALT : OAM_PEND;
               end
            end
            OAM_PEND:  if (cpu_re) oam_state_d = OAM_HALT;
            OAM_HALT:  oam_state_d = cpu_cyc_par ? OAM_READ : OAM_ALIGN;
            OAM_ALIGN: oam_state_d = OAM_READ;
            OAM_READ: begin
               // Holds here through put cycles and slots taken by the DMC.
               if (oam_slot_grant) begin
                  oam_wr_data_d = mem_rd_data;
                  oam_state_d   = OAM_WRITE;
               end
            end
            OAM_WRITE: begin
               cnt_d       = cnt_q + 8'd1;
               oam_state_d = (cnt_q == LAST_CNT) ? OAM_IDLE : OAM_READ;
            end
            default: oam_state_d = OAM_IDLE;
         endcase
      end
   end

   // OAM sequencer registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         oam_state_q   <= OAM_IDLE;
         page_q        <= 8'h00;
         cnt_q         <= 8'h00;
         oam_wr_data_q <= 8'h00;
      end else begin
         oam_state_q   <= oam_state_d;
         page_q        <= page_d;
         cnt_q         <= cnt_d;
         oam_wr_data_q <= oam_wr_data_d;
      end
   end

   // Bus mux: CPU pass-through unless a DMA sequencer is using the cycle.
   always_comb begin
      mem_addr = cpu_addr;
      mem_re   = cpu_re;
      if (dmc_slot_grant) begin
         mem_addr = dmc_addr;
         mem_re   = 1'b1;
      end else begin
         unique case (oam_state_q)
            OAM_ALIGN: mem_re = 1'b0;
            OAM_READ: begin
               mem_addr = {page_q, cnt_q};
               mem_re   = oam_slot_grant;
            end
            OAM_WRITE: begin
               mem_addr = OAMDATA_ADDR;
               mem_re   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign oam_wr_en   = (oam_state_q == OAM_WRITE);
   assign oam_wr_data = oam_wr_data_q;
   assign cpu_sus     = oam_active || dmc_busy;
   assign dma_busy    = (oam_state_q != OAM_IDLE) || dmc_busy;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: steps CPU cycles one at a time and checks bus
// traffic against cycle counts and byte order derived from the NES DMA rules.
module tb_dma_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset_n, cpu_clk_en, cpu_cyc_par;
   logic        oam_dma_start, dmc_req, cpu_re;
   logic [7:0]  oam_dma_page, mem_rd_data;
   logic [15:0] dmc_addr, cpu_addr;
   logic [15:0] mem_addr;
   logic        mem_re, cpu_sus, oam_wr_en, dmc_ack, dma_busy;
   logic [7:0]  oam_wr_data, dmc_data;

   int checks = 0;
   int errors = 0;

   localparam logic [15:0] CPU_PC  = 16'h8123;
   localparam logic [15:0] DMC_ADR = 16'hC000;

   always #5 clock = ~clock;

   dma_bus_arbiter dut (
      .clock(clock), .reset_n(reset_n), .cpu_clk_en(cpu_clk_en), .cpu_cyc_par(cpu_cyc_par),
      .oam_dma_start(oam_dma_start), .oam_dma_page(oam_dma_page), .dmc_req(dmc_req),
      .dmc_addr(dmc_addr), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .mem_rd_data(mem_rd_data),
      .mem_addr(mem_addr), .mem_re(mem_re), .cpu_sus(cpu_sus), .oam_wr_en(oam_wr_en),
      .oam_wr_data(oam_wr_data), .dmc_ack(dmc_ack), .dmc_data(dmc_data), .dma_busy(dma_busy)
   );

   // One CPU cycle: enable for one master clock, then two idle clocks.
   task automatic tick();
      cpu_clk_en = 1'b1;
      @(negedge clock);
      cpu_clk_en  = 1'b0;
      cpu_cyc_par = ~cpu_cyc_par;
      repeat (2) @(negedge clock);
   endtask

   task automatic settle();
      mem_rd_data = 8'($urandom);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cpu_clk_en = 1'b0; cpu_cyc_par = 1'b0;
      oam_dma_start = 1'b0; oam_dma_page = 8'h00; dmc_req = 1'b0;
      dmc_addr = DMC_ADR; cpu_addr = CPU_PC; cpu_re = 1'b1; mem_rd_data = 8'h00;
      repeat (3) @(negedge clock);
      #1;
      checks++;
      if ({cpu_sus, oam_wr_en, dmc_ack, dma_busy} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {cpu_sus, oam_wr_en, dmc_ack, dma_busy});
      end
      checks++;
      if (oam_wr_data !== 8'h00 || dmc_data !== 8'h00) begin
         errors++; $display("FAIL reset_data got %h/%h want 00/00", oam_wr_data, dmc_data);
      end
      checks++;
      if (mem_addr !== CPU_PC || mem_re !== 1'b1) begin
         errors++; $display("FAIL reset_pass got %h/%b want %h/1", mem_addr, mem_re, CPU_PC);
      end
      cpu_addr = 16'h1234; cpu_re = 1'b0;
      #1;
      checks++;
      if (mem_addr !== 16'h1234 || mem_re !== 1'b0) begin
         errors++; $display("FAIL reset_pass2 got %h/%b want 1234/0", mem_addr, mem_re);
      end
      cpu_addr = CPU_PC; cpu_re = 1'b1;
      reset_n = 1'b1;
      repeat (3) tick();
   endtask

   // Full OAM transfer with optional CPU-write delay, DMC injection at byte
   // 100, and an ignored second start. Expectations come from the rules:
   // halt on first read cycle, 513/514 suspended cycles, +2 per stolen slot.
   task automatic run_oam(input logic [7:0] page, input int pend, input logic halt_par,
                          input bit with_dmc, input bit poke, input string tag);
      int h, budget, exp_total, exp_first_rd, exp_dmc_cyc;
      int first_sus = -1, last_sus = -1, sus_cnt = 0, nrd = 0, nwr = 0, first_rd = -1;
      int bad_addr = 0, bad_par = 0, bad_data = 0, bad_wre = 0;
      int dmc_rd = 0, dmc_rd_cyc = -1, dmc_ack_cnt = 0, req_cyc = -1;
      logic req_par, align_re, hp;
      logic [7:0] exp_b, dmc_exp, dmc_got;
      logic [7:0] q[$];
      req_par = 1'b0; align_re = 1'bx; dmc_exp = 8'h00; dmc_got = 8'h00;
      dmc_req = 1'b0;
      hp = cpu_cyc_par ^ ((pend % 2) == 0);
      if (hp != halt_par) tick();
      h            = 1 + pend;
      exp_total    = (halt_par ? 513 : 514) + (with_dmc ? 2 : 0);
      exp_first_rd = h + (halt_par ? 1 : 2);
      budget       = h + exp_total + 6;
      for (int c = 0; c < budget; c++) begin
         oam_dma_start = (c == 0) || (poke && c == 40);
         oam_dma_page  = (c == 0) ? page : 8'h5A;
         cpu_re        = (c >= pend);
         if (with_dmc && nwr == 100 && req_cyc < 0) begin
            dmc_req = 1'b1; req_cyc = c; req_par = cpu_cyc_par;
         end
         settle();
         if (cpu_sus === 1'b1) begin
            if (first_sus < 0) first_sus = c;
            last_sus = c; sus_cnt++;
         end
         if (c == h + 1) align_re = mem_re;
         if (mem_re === 1'b1 && mem_addr === DMC_ADR) begin
            dmc_rd++; dmc_rd_cyc = c; dmc_exp = mem_rd_data;
         end else if (mem_re === 1'b1 && cpu_sus === 1'b1 && mem_addr[15:8] === page) begin
            if (first_rd < 0) first_rd = c;
            if (mem_addr[7:0] !== nrd[7:0]) bad_addr++;
            if (cpu_cyc_par) bad_par++;
            q.push_back(mem_rd_data);
            nrd++;
         end
         if (oam_wr_en === 1'b1) begin
            nwr++;
            if (mem_re !== 1'b0) bad_wre++;
            if (q.size() == 0) bad_data++;
            else begin
               exp_b = q.pop_front();
               if (oam_wr_data !== exp_b) bad_data++;
            end
         end
         if (dmc_ack === 1'b1) begin
            dmc_ack_cnt++; dmc_got = dmc_data; dmc_req = 1'b0;
         end
         tick();
      end
      oam_dma_start = 1'b0;
      dmc_req = 1'b0;
      settle();
      checks++;
      if (first_sus != h) begin
         errors++; $display("FAIL %s halt_cycle got %0d want %0d", tag, first_sus, h);
      end
      checks++;
      if (sus_cnt != exp_total || last_sus - first_sus + 1 != sus_cnt) begin
         errors++; $display("FAIL %s sus_cycles got %0d (span %0d) want %0d", tag, sus_cnt, last_sus - first_sus + 1, exp_total);
      end
      checks++;
      if (nrd != 256 || nwr != 256) begin
         errors++; $display("FAIL %s byte_counts got rd %0d wr %0d want 256/256", tag, nrd, nwr);
      end
      checks++;
      if (bad_addr != 0 || bad_par != 0) begin
         errors++; $display("FAIL %s read_addr_order got %0d bad addr %0d bad par want 0", tag, bad_addr, bad_par);
      end
      checks++;
      if (bad_data != 0 || bad_wre != 0) begin
         errors++; $display("FAIL %s write_data got %0d bad data %0d bad re want 0", tag, bad_data, bad_wre);
      end
      checks++;
      if (first_rd != exp_first_rd) begin
         errors++; $display("FAIL %s first_read got %0d want %0d", tag, first_rd, exp_first_rd);
      end
      if (!halt_par) begin
         checks++;
         if (align_re !== 1'b0) begin
            errors++; $display("FAIL %s align_mem_re got %b want 0", tag, align_re);
         end
      end
      if (with_dmc) begin
         exp_dmc_cyc = req_cyc + (req_par ? 1 : 2);
         checks++;
         if (dmc_rd != 1 || dmc_rd_cyc != exp_dmc_cyc) begin
            errors++; $display("FAIL %s dmc_slot got %0d reads at %0d want 1 at %0d", tag, dmc_rd, dmc_rd_cyc, exp_dmc_cyc);
         end
         checks++;
         if (dmc_ack_cnt != 1 || dmc_got !== dmc_exp) begin
            errors++; $display("FAIL %s dmc_ack got %0d acks data %h want 1 data %h", tag, dmc_ack_cnt, dmc_got, dmc_exp);
         end
      end else begin
         checks++;
         if (dmc_rd != 0 || dmc_ack_cnt != 0) begin
            errors++; $display("FAIL %s dmc_quiet got %0d reads %0d acks want 0/0", tag, dmc_rd, dmc_ack_cnt);
         end
      end
      checks++;
      if (cpu_sus !== 1'b0 || dma_busy !== 1'b0) begin
         errors++; $display("FAIL %s end_idle got sus %b busy %b want 0/0", tag, cpu_sus, dma_busy);
      end
   endtask

   task automatic test_oam_par1();
      run_oam(8'h02, 0, 1'b1, 1'b0, 1'b0, "oam_par1");
   endtask

   task automatic test_oam_par0();
      run_oam(8'h02, 0, 1'b0, 1'b0, 1'b1, "oam_par0");
   endtask

   task automatic test_oam_pend();
      run_oam(8'(($urandom_range(1, 7))), 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "oam_pend");
   endtask

   task automatic test_dmc_during_oam();
      run_oam(8'h02, 0, 1'b1, 1'b1, 1'b0, "dmc_in_oam");
   endtask

   // Standalone DMC fetch; want_par is the parity of the DUMMY cycle.
   task automatic test_dmc_idle(input logic want_par);
      int sus_cnt = 0, first_sus = -1, rd_cnt = 0, rd_cyc = -1, ack_cnt = 0, ack_cyc = -1;
      int exp_rd;
      logic [7:0] rd_dat, ack_dat;
      rd_dat = 8'h00; ack_dat = 8'h11;
      if (cpu_cyc_par != want_par) tick();
      exp_rd = want_par ? 3 : 4;
      for (int c = 0; c < 10; c++) begin
         cpu_re = 1'b1;
         if (c == 0) dmc_req = 1'b1;
         settle();
         if (cpu_sus === 1'b1) begin
            if (first_sus < 0) first_sus = c;
            sus_cnt++;
         end
         if (mem_re === 1'b1 && mem_addr === DMC_ADR) begin
            rd_cnt++; rd_cyc = c; rd_dat = mem_rd_data;
            if (cpu_cyc_par) rd_cyc = -2;
         end
         if (dmc_ack === 1'b1) begin
            ack_cnt++; ack_cyc = c; ack_dat = dmc_data; dmc_req = 1'b0;
         end
         tick();
      end
      dmc_req = 1'b0;
      checks++;
      if (rd_cnt != 1 || rd_cyc != exp_rd) begin
         errors++; $display("FAIL dmc_idle_read par%0b got %0d reads at %0d want 1 at %0d", want_par, rd_cnt, rd_cyc, exp_rd);
      end
      checks++;
      if (first_sus != 1 || sus_cnt != exp_rd) begin
         errors++; $display("FAIL dmc_idle_sus par%0b got start %0d len %0d want 1/%0d", want_par, first_sus, sus_cnt, exp_rd);
      end
      checks++;
      if (ack_cnt != 1 || ack_cyc != exp_rd + 1 || ack_dat !== rd_dat) begin
         errors++; $display("FAIL dmc_idle_ack par%0b got %0d at %0d data %h want 1 at %0d data %h", want_par, ack_cnt, ack_cyc, ack_dat, exp_rd + 1, rd_dat);
      end
   endtask

   task automatic test_reset_mid_dma();
      int nwr = 0, stray = 0;
      cpu_re = 1'b1;
      oam_dma_page = 8'h03; oam_dma_start = 1'b1;
      settle(); tick();
      oam_dma_start = 1'b0;
      for (int c = 0; c < 300 && nwr < 50; c++) begin
         settle();
         if (oam_wr_en === 1'b1) nwr++;
         tick();
      end
      checks++;
      if (nwr != 50) begin
         errors++; $display("FAIL rst_mid_reach got %0d writes want 50", nwr);
      end
      reset_n = 1'b0;
      settle(); tick();
      reset_n = 1'b1;
      cpu_addr = 16'h4567; cpu_re = 1'b0;
      settle();
      checks++;
      if (cpu_sus !== 1'b0 || oam_wr_en !== 1'b0 || dma_busy !== 1'b0 || oam_wr_data !== 8'h00) begin
         errors++; $display("FAIL rst_mid_state got sus %b wr %b busy %b data %h want 0 0 0 00", cpu_sus, oam_wr_en, dma_busy, oam_wr_data);
      end
      checks++;
      if (mem_addr !== 16'h4567 || mem_re !== 1'b0) begin
         errors++; $display("FAIL rst_mid_pass got %h/%b want 4567/0", mem_addr, mem_re);
      end
      cpu_addr = CPU_PC; cpu_re = 1'b1;
      for (int c = 0; c < 20; c++) begin
         settle();
         if (oam_wr_en !== 1'b0 || cpu_sus !== 1'b0) stray++;
         tick();
      end
      checks++;
      if (stray != 0) begin
         errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", stray);
      end
      run_oam(8'h07, 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rst_restart");
   endtask

   initial begin
      test_reset();
      test_oam_par1();
      test_oam_par0();
      test_oam_pend();
      test_dmc_idle(1'b1);
      test_dmc_idle(1'b0);
      test_dmc_during_oam();
      test_reset_mid_dma();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
